// File: rtl/dram_pkg.sv
// rtl/dram_pkg.sv - shared DRAM command, sequencer state and row status definitions
package dram_pkg;

    localparam int ROW_BITS  = 16;
    localparam int COL_BITS  = 10;

    localparam int T_RP_DEF  = 4;
    localparam int T_RCD_DEF = 4;
    localparam int T_RFC_DEF = 20;

    localparam logic [1:0] ROW_IDLE     = 2'b00;
    localparam logic [1:0] ROW_HIT      = 2'b01;
    localparam logic [1:0] ROW_MISS     = 2'b10;
    localparam logic [1:0] ROW_CONFLICT = 2'b11;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_ACT,
        CMD_PRE,
        CMD_PREA,
        CMD_RD,
        CMD_WR,
        CMD_REF
    } dram_cmd_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOOKUP,
        S_PRE,
        S_WAIT_RP,
        S_ACT,
        S_WAIT_RCD,
        S_CAS,
        S_PREA,
        S_WAIT_PREA,
        S_REF,
        S_WAIT_RFC
    } seq_state_t;

endpackage

// File: rtl/dram_timing_cnt.sv
// rtl/dram_timing_cnt.sv - loadable saturating down counter with zero flag
module dram_timing_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/dram_cmd_sequencer.sv
// rtl/dram_cmd_sequencer.sv - per-request PRE/ACT/RD/WR sequencer with refresh arbitration
module dram_cmd_sequencer
    import dram_pkg::*;
#(
    parameter int T_RP  = T_RP_DEF,
    parameter int T_RCD = T_RCD_DEF,
    parameter int T_RFC = T_RFC_DEF,
    parameter int CNT_W = 8
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [1:0]          req_bg,
    input  logic [1:0]          req_bank,
    input  logic [ROW_BITS-1:0] req_row,
    input  logic [COL_BITS-1:0] req_col,
    input  logic                refresh_req,
    output logic                refresh_ack,
    output logic                ro_req_en,
    output logic [1:0]          ro_bg,
    output logic [1:0]          ro_bank,
    output logic [ROW_BITS-1:0] ro_row,
    input  logic [1:0]          row_stat,
    output logic                row_resolve,
    output logic                ro_refresh,
    output logic                cmd_valid,
    output dram_cmd_t           cmd,
    output logic [1:0]          cmd_bg,
    output logic [1:0]          cmd_bank,
    output logic [ROW_BITS-1:0] cmd_addr,
    output logic                done
);

    seq_state_t          state, state_nxt;
    logic                ready_q;
    logic                lat_write;
    logic [COL_BITS-1:0] lat_col;
    logic                cnt_load, cnt_zero;
    logic [CNT_W-1:0]    cnt_val;

    assign req_ready = ready_q && !refresh_req;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (refresh_req)                 state_nxt = S_PREA;
                else if (req_valid && req_ready) state_nxt = S_LOOKUP;
            end
            S_LOOKUP: begin
                case (row_stat)
                    ROW_HIT:      state_nxt = S_CAS;
                    ROW_MISS:     state_nxt = S_ACT;
                    ROW_CONFLICT: state_nxt = S_PRE;
                    default:      state_nxt = S_LOOKUP;
                endcase
            end
            // Issue states fall straight through when the programmed gap is a single cycle
            S_PRE, S_WAIT_RP:      if (cnt_zero) state_nxt = S_ACT;  else state_nxt = S_WAIT_RP;
            S_ACT, S_WAIT_RCD:     if (cnt_zero) state_nxt = S_CAS;  else state_nxt = S_WAIT_RCD;
            S_CAS:                 state_nxt = refresh_req ? S_PREA : S_IDLE;
            S_PREA, S_WAIT_PREA:   if (cnt_zero) state_nxt = S_REF;  else state_nxt = S_WAIT_PREA;
            S_REF, S_WAIT_RFC:     if (cnt_zero) state_nxt = S_IDLE; else state_nxt = S_WAIT_RFC;
            default:               state_nxt = S_IDLE;
        endcase
    end

    // Counter is loaded on the edge that enters an issue state, so the gap counts from the command cycle
    always_comb begin
        cnt_load = 1'b1;
        cnt_val  = '0;
        case (state_nxt)
            S_PRE, S_PREA: cnt_val = CNT_W'(T_RP - 1);
            S_ACT:         cnt_val = CNT_W'(T_RCD - 1);
            S_REF:         cnt_val = CNT_W'(T_RFC - 1);
            default:       cnt_load = 1'b0;
        endcase
    end

    dram_timing_cnt #(.CNT_W(CNT_W)) u_timing_cnt (
        .CLK      (CLK),
        .nRST     (nRST),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state       <= S_IDLE;
            ready_q     <= 1'b0;
            lat_write   <= 1'b0;
            lat_col     <= '0;
            ro_bg       <= '0;
            ro_bank     <= '0;
            ro_row      <= '0;
            ro_req_en   <= 1'b0;
            row_resolve <= 1'b0;
            ro_refresh  <= 1'b0;
            refresh_ack <= 1'b0;
            done        <= 1'b0;
            cmd_valid   <= 1'b0;
            cmd         <= CMD_NOP;
            cmd_bg      <= '0;
            cmd_bank    <= '0;
            cmd_addr    <= '0;
        end else begin
            state       <= state_nxt;
            ready_q     <= (state_nxt == S_IDLE);
            ro_req_en   <= (state_nxt == S_LOOKUP);
            row_resolve <= (state_nxt == S_ACT);
            done        <= (state_nxt == S_CAS);
            ro_refresh  <= (state_nxt == S_REF);
            refresh_ack <= (state_nxt == S_REF);

            if (state == S_IDLE && state_nxt == S_LOOKUP) begin
                lat_write <= req_write;
                lat_col   <= req_col;
                ro_bg     <= req_bg;
                ro_bank   <= req_bank;
                ro_row    <= req_row;
            end

            cmd_valid <= 1'b0;
            cmd       <= CMD_NOP;
            cmd_bg    <= '0;
            cmd_bank  <= '0;
            cmd_addr  <= '0;
            case (state_nxt)
                S_PRE: begin
                    cmd_valid <= 1'b1;
                    cmd       <= CMD_PRE;
                    cmd_bg    <= ro_bg;
                    cmd_bank  <= ro_bank;
                end
                S_ACT: begin
                    cmd_valid <= 1'b1;
                    cmd       <= CMD_ACT;
                    cmd_bg    <= ro_bg;
                    cmd_bank  <= ro_bank;
                    cmd_addr  <= ro_row;
                end
                S_CAS: begin
                    cmd_valid <= 1'b1;
                    cmd       <= lat_write ? CMD_WR : CMD_RD;
                    cmd_bg    <= ro_bg;
                    cmd_bank  <= ro_bank;
                    cmd_addr  <= ROW_BITS'(lat_col);
                end
                S_PREA: begin
                    cmd_valid <= 1'b1;
                    cmd       <= CMD_PREA;
                end
                S_REF: begin
                    cmd_valid <= 1'b1;
                    cmd       <= CMD_REF;
                end
                default: ;
            endcase
        end
    end

endmodule
